renode_gpio_bridge: RTL and testbench
=====================================

RENODE_GPIO_BRIDGE -- requirements
Module: renode_gpio_bridge

Interface
REQ-001 SHALL have parameter InputsCount, default 1, number of inputs monitored for Renode (1..64).
REQ-002 SHALL have parameter OutputsCount, default 1, number of outputs driven by Renode (1..64).
REQ-003 SHALL have parameter EventFifoDepth, default 8, input-change event FIFO entries (power of two, >=2).
REQ-004 SHALL have parameter SyncStages, default 2, input synchroniser flops (>=1).
REQ-005 SHALL have parameter OutputsResetValue, default 0, OutputsCount-bit reset value of renode_outputs.
REQ-006 SHALL have one clock and a synchronous active-high reset: clk input 1 rising-edge clock; rst input 1 synchronous active-high reset.
REQ-007 renode_inputs  input  InputsCount  asynchronous inputs to report to Renode.
REQ-008 renode_outputs  output  OutputsCount  registered outputs driven by Renode.
REQ-009 event_valid / event_ready  output / input  1 / 1  change-event handshake toward Renode.
REQ-010 event_number  output  64  index of the changed input; event_value  output  1  its new level.
REQ-011 event_overflow  output  1  sticky: at least one event was dropped.
REQ-012 cmd_valid / cmd_ready  input / output  1 / 1  output-command handshake from Renode.
REQ-013 cmd_number  input  64  output index; cmd_value  input  1  level to drive.
REQ-014 resp_valid  output  1  one-cycle response pulse; resp_error  output  1  qualifies resp_valid (1 = rejected).

Function
REQ-015 Inputs SHALL pass through SyncStages flops; change detection compares the last sync stage against a registered previous value.
REQ-016 Each detected change SHALL set that input's pending bit; a pending bit set and cleared in one cycle SHALL remain set.
REQ-017 Scanner SHALL move the lowest-index pending bit into the FIFO, one per cycle, when the FIFO is not full; value pushed = current synchronised level.
REQ-018 Multiple simultaneous changes SHALL be pushed in ascending index order over consecutive cycles.
REQ-019 Pending bit of an input that toggles again before being pushed SHALL stay single; the pushed value is the level at push time (changes coalesce).
REQ-020 FIFO full with pending bits: scanner SHALL stall; pending bits SHALL be held, not lost.
REQ-021 A new change on an input whose pending bit is already set while the FIFO is full SHALL set event_overflow; it stays set until rst.
REQ-022 event_valid = FIFO not empty; pop on event_valid & event_ready; event_number/event_value SHALL be stable while event_valid & !event_ready.
REQ-023 Push and pop in the same cycle on a full FIFO SHALL both succeed; count unchanged.
REQ-024 Command FSM states: IDLE, APPLY, RESP; cmd_ready = 1 only in IDLE.
REQ-025 IDLE: cmd_valid -> latch number/value -> APPLY.
REQ-026 APPLY: cmd_number < OutputsCount -> renode_outputs[cmd_number] <= cmd_value, resp_error <= 0; otherwise no output changes, resp_error <= 1 -> RESP.
REQ-027 Range check SHALL use the full 64-bit cmd_number; no truncation aliasing.
REQ-028 RESP: resp_valid = 1 for exactly one cycle -> IDLE; command latency accept-to-response = 2 cycles; maximum throughput one command per 3 cycles.
REQ-029 Every command SHALL receive exactly one response.

Reset
REQ-030 rst SHALL, on a clk edge: renode_outputs = OutputsResetValue, FSM = IDLE, resp_valid = 0, resp_error = 0, FIFO empty, event_valid = 0, pending bits = 0, event_overflow = 0.
REQ-031 During reset, synchroniser and previous-value registers SHALL load the current synchronised input value, so no events are generated for levels present at reset release.
REQ-032 rst asserted mid-command SHALL abort it with no response; rst asserted with events queued SHALL discard them.

Verification
REQ-033 Input 3 rises, InputsCount=8, SyncStages=2 -> event_valid 3 cycles later with number=3, value=1; with ready held, it pops the next cycle.
REQ-034 Inputs 5, 1 and 6 rise together -> events in order 1, 5, 6 on consecutive cycles, all value=1.
REQ-035 EventFifoDepth=4, event_ready=0, toggle 6 distinct inputs -> 4 events queued; 2 events held pending; overflow stays 0; re-toggling a pending input -> overflow=1.
REQ-036 cmd number=2 value=1, OutputsCount=4 -> renode_outputs=4'b0100, resp_valid with resp_error=0, 2 cycles after accept.
REQ-037 cmd number=4 (OutputsCount=4) and number=64'h1_0000_0002 -> resp_error=1 for both; renode_outputs unchanged.
REQ-038 rst asserted during APPLY with OutputsResetValue=4'b1010 -> outputs=4'b1010, no resp_valid, cmd_ready=1 the cycle after rst deasserts.

Source files
------------

// File: rtl/renode_gpio_bridge.sv
// GPIO bridge between fabric and Renode. Synchronised inputs produce change events
// through a FIFO. Commands from Renode drive individual output bits and get a one-cycle response.
module renode_gpio_bridge #(
    parameter int InputsCount    = 1,
    parameter int OutputsCount   = 1,
    parameter int EventFifoDepth = 8,
    parameter int SyncStages     = 2,
    parameter logic [OutputsCount-1:0] OutputsResetValue = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [InputsCount-1:0]  renode_inputs,
    output logic [OutputsCount-1:0] renode_outputs,
    output logic                    event_valid,
    input  logic                    event_ready,
    output logic [63:0]             event_number,
    output logic                    event_value,
    output logic                    event_overflow,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [63:0]             cmd_number,
    input  logic                    cmd_value,
    output logic                    resp_valid,
    output logic                    resp_error
);
    localparam int IdxW = (InputsCount > 1) ? $clog2(InputsCount) : 1;
    localparam int PtrW = $clog2(EventFifoDepth);
    localparam int CntW = PtrW + 1;

    logic [InputsCount-1:0] sync_q [SyncStages];
    logic [InputsCount-1:0] prev_q, pending_q, pending_d;
    logic [InputsCount-1:0] level, chg, eff, push_oh;
    logic [IdxW:0]          mem_q [EventFifoDepth];
    logic [PtrW-1:0]        wr_q, rd_q;
    logic [CntW-1:0]        count_q;
    logic [IdxW-1:0]        push_idx;
    logic                   push_val, push, pop, full, ovf_set, overflow_q;

    // Reset loads the live input level so levels present at release raise no events.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SyncStages; k++) sync_q[k] <= renode_inputs;
            prev_q <= renode_inputs;
        end else begin
            sync_q[0] <= renode_inputs;
            for (int k = 1; k < SyncStages; k++) sync_q[k] <= sync_q[k-1];
            prev_q <= level;
        end
    end

    assign level       = sync_q[SyncStages-1];
    assign chg         = level ^ prev_q;
    assign full        = (count_q == CntW'(EventFifoDepth));
    assign event_valid = (count_q != '0);
    assign pop         = event_valid & event_ready;

    always_comb begin
        eff      = pending_q | chg;
        push_idx = '0;
        push_val = 1'b0;
        for (int i = InputsCount - 1; i >= 0; i--) begin
            if (eff[i]) begin
                push_idx = IdxW'(i);
                push_val = level[i];
            end
        end
        push = (|eff) & (~full | pop);
        for (int i = 0; i < InputsCount; i++) push_oh[i] = push && (push_idx == IdxW'(i));
        // A fresh change on a bit being pushed this cycle keeps it pending.
        pending_d = (eff & ~push_oh) | (chg & pending_q);
        ovf_set   = full & (|(chg & pending_q));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q       <= '0;
            rd_q       <= '0;
            count_q    <= '0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_q <= wr_q + PtrW'(1);
            if (pop)  rd_q <= rd_q + PtrW'(1);
            count_q    <= count_q + CntW'(push) - CntW'(pop);
            pending_q  <= pending_d;
            overflow_q <= overflow_q | ovf_set;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= {push_idx, push_val};
    end

    assign event_number   = 64'(mem_q[rd_q][IdxW:1]);
    assign event_value    = mem_q[rd_q][0];
    assign event_overflow = overflow_q;

    typedef enum logic [1:0] {IDLE, APPLY, RESP} state_t;
    state_t                  state_q;
    logic [63:0]             num_q;
    logic                    val_q, in_range, resp_valid_q, resp_err_q;
    logic [OutputsCount-1:0] out_q, out_apply;

    // Full-width compare: no aliasing of large command numbers onto low bits.
    always_comb begin
        out_apply = out_q;
        in_range  = (num_q < 64'(OutputsCount));
        for (int i = 0; i < OutputsCount; i++) begin
            if (num_q == 64'(i)) out_apply[i] = val_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            out_q        <= OutputsResetValue;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    resp_valid_q <= 1'b0;
                    if (cmd_valid) begin
                        num_q   <= cmd_number;
                        val_q   <= cmd_value;
                        state_q <= APPLY;
                    end
                end
                APPLY: begin
                    out_q        <= out_apply;
                    resp_err_q   <= ~in_range;
                    resp_valid_q <= 1'b1;
                    state_q      <= RESP;
                end
                RESP: begin
                    resp_valid_q <= 1'b0;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready      = (state_q == IDLE);
    assign resp_valid     = resp_valid_q;
    assign resp_error     = resp_err_q;
    assign renode_outputs = out_q;
endmodule

// File: tb/tb_renode_gpio_bridge.sv
// Bench for renode_gpio_bridge: directed scenarios plus randomized traffic.
// Expected values come from a queue-based reference model.
module tb_renode_gpio_bridge;
    localparam int NI = 8, NO = 4, DEP = 4, SS = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [NI-1:0] in_r;
    logic [NO-1:0] renode_outputs;
    logic          event_valid, event_ready, event_value, event_overflow;
    logic [63:0]   event_number;
    logic          cmd_valid, cmd_ready, cmd_value, resp_valid, resp_error;
    logic [63:0]   cmd_number;

    always #5 clk = ~clk;

    renode_gpio_bridge #(
        .InputsCount(NI), .OutputsCount(NO), .EventFifoDepth(DEP),
        .SyncStages(SS), .OutputsResetValue(4'b1010)
    ) dut (
        .clk(clk), .rst(rst), .renode_inputs(in_r), .renode_outputs(renode_outputs),
        .event_valid(event_valid), .event_ready(event_ready), .event_number(event_number),
        .event_value(event_value), .event_overflow(event_overflow),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_number(cmd_number),
        .cmd_value(cmd_value), .resp_valid(resp_valid), .resp_error(resp_error)
    );

    int checks = 0, errors = 0;

    // Reference model: input history, pending set, event queue, sticky overflow.
    logic [NI-1:0] m_hist [SS];
    logic [NI-1:0] m_prev, m_pend;
    logic [7:0]    m_fifo [$];
    logic          m_ovf;
    logic [NO-1:0] m_out;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_tick();
        logic [NI-1:0] lvl, chg, nxt;
        logic          full, pop;
        int            lo;
        if (rst) begin
            for (int k = 0; k < SS; k++) m_hist[k] = in_r;
            m_prev = in_r;
            m_pend = '0;
            m_fifo.delete();
            m_ovf  = 1'b0;
        end else begin
            lvl  = m_hist[SS-1];
            chg  = lvl ^ m_prev;
            full = (m_fifo.size() == DEP);
            pop  = (m_fifo.size() > 0) && event_ready;
            nxt  = m_pend | chg;
            lo   = -1;
            for (int i = 0; i < NI; i++) if (nxt[i] && lo < 0) lo = i;
            if (full && ((chg & m_pend) != '0)) m_ovf = 1'b1;
            if (pop) void'(m_fifo.pop_front());
            if (lo >= 0 && (!full || pop)) begin
                if (!(chg[lo] && m_pend[lo])) nxt[lo] = 1'b0;
                m_fifo.push_back(8'(lo * 2 + int'(lvl[lo])));
            end
            m_pend = nxt;
            for (int k = SS - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = in_r;
            m_prev    = lvl;
        end
    endtask

    task automatic step();
        logic [7:0] e;
        model_tick();
        @(posedge clk);
        #1;
        chk("event_valid", event_valid, m_fifo.size() != 0);
        if (m_fifo.size() != 0) begin
            e = m_fifo[0];
            chk("event_number", event_number, 64'(e[7:1]));
            chk("event_value", event_value, e[0]);
        end
        chk("event_overflow", event_overflow, m_ovf);
    endtask

    task automatic do_cmd(input logic [63:0] n, input logic v);
        int k = 0;
        logic exp_err = (n >= 64'(NO));
        cmd_number = n;
        cmd_value  = v;
        cmd_valid  = 1'b1;
        while (cmd_ready !== 1'b1 && k < 8) begin step(); k++; end
        chk("cmd_ready_wait", cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
        chk("cmd_ready_busy", cmd_ready, 0);
        chk("resp_early", resp_valid, 0);
        if (!exp_err) m_out[n[1:0]] = v;
        step();
        chk("resp_valid", resp_valid, 1);
        chk("resp_error", resp_error, exp_err);
        chk("outputs", renode_outputs, m_out);
        step();
        chk("resp_pulse", resp_valid, 0);
        chk("cmd_ready_back", cmd_ready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_r = '0; event_ready = 1'b0;
        cmd_valid = 1'b0; cmd_number = '0; cmd_value = 1'b0;
        m_out = 4'b1010;
        step(); step();
        chk("rst_outputs", renode_outputs, 4'b1010);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_error", resp_error, 0);
        rst = 1'b0;
        step();

        // Single rising input: event three cycles later, popped on the next.
        event_ready = 1'b1;
        in_r[3] = 1'b1;
        step(); chk("lat_c1", event_valid, 0);
        step(); chk("lat_c2", event_valid, 0);
        step(); chk("lat_c3", event_valid, 1);
        chk("lat_num", event_number, 3);
        chk("lat_val", event_value, 1);
        step(); chk("lat_pop", event_valid, 0);

        // Simultaneous rises drain in ascending order.
        in_r = in_r | 8'b0110_0010;
        step(); step(); step();
        chk("ord_1", event_number, 1);
        step(); chk("ord_5", event_number, 5);
        step(); chk("ord_6", event_number, 6);
        chk("ord_val", event_value, 1);
        step(); chk("ord_empty", event_valid, 0);

        // FIFO full: pending held, overflow only on re-toggle of a pending input.
        event_ready = 1'b0;
        in_r = in_r ^ 8'b0011_1111;
        for (int i = 0; i < 8; i++) step();
        chk("full_head", event_number, 0);
        chk("full_ovf0", event_overflow, 0);
        in_r[4] = ~in_r[4];
        step(); step();
        chk("ovf_not_yet", event_overflow, 0);
        step();
        chk("ovf_set", event_overflow, 1);
        event_ready = 1'b1;
        for (int i = 0; i < 10; i++) step();
        chk("ovf_sticky", event_overflow, 1);

        // Reset discards queued events.
        event_ready = 1'b0;
        in_r = in_r ^ 8'b1100_0000;
        for (int i = 0; i < 5; i++) step();
        chk("queued", event_valid, 1);
        rst = 1'b1; step();
        chk("rst_discard", event_valid, 0);
        rst = 1'b0; step();
        chk("rst_no_event", event_valid, 0);

        // Commands.
        do_cmd(64'd1, 1'b0);
        do_cmd(64'd3, 1'b0);
        do_cmd(64'd2, 1'b1);
        chk("out_0100", renode_outputs, 4'b0100);
        do_cmd(64'd4, 1'b1);
        do_cmd(64'h1_0000_0002, 1'b1);
        chk("out_unchanged", renode_outputs, 4'b0100);

        // Reset during APPLY aborts the command.
        cmd_number = 64'd0; cmd_value = 1'b1; cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        chk("abort_accepted", cmd_ready, 0);
        rst = 1'b1; step();
        m_out = 4'b1010;
        chk("abort_outputs", renode_outputs, 4'b1010);
        chk("abort_resp", resp_valid, 0);
        rst = 1'b0; step();
        chk("abort_ready", cmd_ready, 1);
        chk("abort_resp2", resp_valid, 0);

        // Randomized input traffic and commands.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 5) == 0) in_r = in_r ^ (8'd1 << $urandom_range(0, NI - 1));
            event_ready = ($urandom_range(0, 2) != 0);
            step();
        end
        event_ready = 1'b1;
        for (int i = 0; i < 12; i++) step();
        for (int i = 0; i < 8; i++) begin
            do_cmd(64'($urandom_range(0, 5)), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
